core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Instruction sequencer for the GPU core array. It fetches 16-bit opcodes from the program memory,
//  broadcasts opcode/execute to every core, and executes the control-flow instructions itself.
//  Control flow covers jump, single-level loop and halt.
//  One program run is triggered per start pulse (e.g. per pixel or per line) and ends with a done pulse.
// PARAMETERS
//  ADDR_W      8     program memory address width; PC wraps modulo 2^ADDR_W
//  MAX_CYCLES  255   cycle budget per run (used only with SEQ_WATCHDOG_EN)
// PORTS
//  clk         in   1       clock; everything sampled on rising edge
//  rst_n       in   1       synchronous reset, active low
//  start       in   1       run request; honoured only in IDLE
//  prog_addr   out  ADDR_W  program memory read address (registered)
//  prog_data   in   16      program word; valid exactly 1 cycle after prog_addr
//  opcode      out  16      opcode to cores (registered)
//  execute     out  1       cores execute opcode on this cycle's edge (registered)
//  busy        out  1       high from cycle after start accepted until done
//  done        out  1       single-cycle pulse at end of run
//  overrun     out  1       run aborted by watchdog; sticky until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, prog_addr=0, opcode=0, execute=0, busy=0, done=0, overrun=0, loop_cnt=0.
//   Reset mid-run abandons the run immediately; no done pulse is issued.
//  FSM states: IDLE -> RUN on start. RUN -> IDLE on HALT or watchdog abort. RUN -> RUN otherwise.
//   start while busy is ignored.
//  Pipeline: start sampled at edge t.
//   t+1: prog_addr=0, busy=1.
//   t+2: prog_data=word0, which is decoded combinationally.
//   t+3: opcode/execute reflect word0.
//   Steady state is 1 instruction/cycle; prog_addr increments each cycle.
//  Decode of prog_data:
//   [15:14]!=11, or [15:14]==11 with [8]==1 -> core instruction. Sets opcode=word, execute=1.
//   [15:14]==11 with [8]==0 -> sequencer-only instruction. Sets execute=0; opcode holds its previous value.
//   Its sub-opcode is [13:11]:
//    00x NOP:     no action.
//    01x HALT:    done=1 next cycle; busy=0; state=IDLE; prefetched word squashed.
//    10x JUMP:    pc <= [7:0] (zero-extended/truncated to ADDR_W); prefetched word squashed (1 bubble).
//    110 SETLOOP: loop_cnt <= [7:0].
//    111 LOOP:    if loop_cnt!=0, loop_cnt-- and jump to [7:0] (1 bubble); else fall through.
//  A squashed word yields execute=0 and is never decoded as control.
//  loop_cnt is 8 bit, single level, and not cleared by start; programs must SETLOOP before LOOP.
//  A LOOP with loop_cnt=0 falls through, giving N+1 body iterations for SETLOOP N.
//  PC wrap: after address 2^ADDR_W-1, fetch continues at 0; no error is raised.
//  done and the first prog_addr of a new run never coincide. start is only accepted in the cycle after done,
//   when state is IDLE.
//  Cores see only opcode/execute and need no knowledge of control instructions.
// CONFIGURATION
//  SEQ_WATCHDOG_EN defined:
//   A cycle counter clears on start accept and increments each RUN cycle.
//   If it reaches MAX_CYCLES while in RUN, the run aborts exactly like HALT: done pulse, overrun=1.
//   HALT and watchdog on the same cycle -> HALT wins, overrun=0.
//  SEQ_WATCHDOG_EN undefined:
//   No counter is built; overrun is tied 0; a program without HALT runs forever.
// STRUCTURE
//  Package seq_pkg: opcode class constants (CLS_LOAD/ALU2/ALU0/MISC), sub-op encodings
//   (SEQ_NOP/HALT/JUMP/SETLOOP/LOOP), and state encodings (ST_IDLE/ST_RUN).
//  Sub-module core_seq_decode: combinational; prog_data -> {is_ctrl, is_halt, is_jump, is_setloop,
//   is_loop, target}. The top level holds the FSM, pc, squash flag, loop_cnt and watchdog.
// TESTING
//  1. Reset, then start pulse; program {0x0005, 0x1A03, 0x5000, 0xD000 HALT}.
//     -> execute=1 on cycles t+3..t+5 with opcodes 0x0005, 0x1A03, 0x5000;
//        done=1 at t+6 (single cycle); busy=0 at t+6.
//  2. JUMP at addr 1 to 0x10; addr 2 holds 0x4242; addr 0x10 holds 0xD000.
//     -> 0x4242 never appears with execute=1; one bubble; done follows.
//  3. SETLOOP 2; body 0x6000; LOOP back to body; HALT.
//     -> exactly 3 execute pulses of 0x6000; loop_cnt=0 at end.
//  4. start asserted continuously during run and at reset deassert.
//     -> a single run per IDLE entry; rst_n=0 mid-run -> all outputs 0 next edge, no done.
//  5. Program without HALT, ADDR_W=4.
//     -> prog_addr wraps 15 -> 0. With SEQ_WATCHDOG_EN and MAX_CYCLES=20: done + overrun=1
//        after 20 RUN cycles; next start clears overrun.
//  6. Store opcode 0xC100 ([15:14]=11, [8]=1).
//     -> forwarded with execute=1, not treated as a control instruction.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the core sequencer: opcode classes, sequencer sub-ops,
// FSM states and the decoded-instruction record.
package seq_pkg;
  // Opcode class in word[15:14]; CLS_MISC with word[8]=0 is a sequencer instruction
  localparam logic [1:0] CLS_LOAD = 2'b00;
  localparam logic [1:0] CLS_ALU2 = 2'b01;
  localparam logic [1:0] CLS_ALU0 = 2'b10;
  localparam logic [1:0] CLS_MISC = 2'b11;

  // Sequencer sub-op in word[13:11]; NOP/HALT/JUMP ignore the low bit
  localparam logic [2:0] SEQ_NOP     = 3'b000;
  localparam logic [2:0] SEQ_HALT    = 3'b010;
  localparam logic [2:0] SEQ_JUMP    = 3'b100;
  localparam logic [2:0] SEQ_SETLOOP = 3'b110;
  localparam logic [2:0] SEQ_LOOP    = 3'b111;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic       is_ctrl;
    logic       is_halt;
    logic       is_jump;
    logic       is_setloop;
    logic       is_loop;
    logic [7:0] target;
  } dec_t;
endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer bus: run control, program memory fetch port and core broadcast.
interface core_sequencer_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic [15:0]       opcode;
  logic              execute;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (input start, prog_data,
                  output prog_addr, opcode, execute, busy, done, overrun);
  modport slave  (output start, prog_data,
                  input prog_addr, opcode, execute, busy, done, overrun);
endinterface

// File: rtl/core_sequencer_decode.sv
// Combinational decode of one program word into control-flow flags.
module core_seq_decode
  import seq_pkg::*;
(
  input  logic [15:0] word,
  output dec_t        dec
);
  logic [2:0] sub;

  // Classify the word; everything that is not a sequencer op goes to the cores
  always_comb begin
    sub            = word[13:11];
    dec            = '0;
    dec.is_ctrl    = (word[15:14] == CLS_MISC) && !word[8];
    dec.is_halt    = dec.is_ctrl && (sub[2:1] == SEQ_HALT[2:1]);
    dec.is_jump    = dec.is_ctrl && (sub[2:1] == SEQ_JUMP[2:1]);
    dec.is_setloop = dec.is_ctrl && (sub == SEQ_SETLOOP);
    dec.is_loop    = dec.is_ctrl && (sub == SEQ_LOOP);
    dec.target     = word[7:0];
  end
endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: fetches program words, broadcasts core opcodes and
// runs jump / single-level loop / halt itself.
// Optional SEQ_WATCHDOG_EN: aborts a run after MAX_CYCLES RUN cycles and flags overrun.
module core_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  core_sequencer_if.master  sif
);
  state_e            state;
  logic [ADDR_W-1:0] pc, tgt;
  logic              dvld;      // prog_data this cycle is a real, unsquashed fetch
  logic [15:0]       opcode_q;
  logic              exec_q, busy_q, done_q, ovr_q;
  logic [7:0]        loop_cnt;
  dec_t              dec;
  logic              v, halt, redirect, wd_hit;

  core_seq_decode u_dec (.word(sif.prog_data), .dec(dec));

  // Qualify the decoded word and form the redirect target
  always_comb begin
    v        = (state == ST_RUN) && dvld;
    halt     = v && dec.is_halt;
    redirect = v && (dec.is_jump || (dec.is_loop && (loop_cnt != 8'd0)));
    tgt      = ADDR_W'(dec.target);
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  assign wd_nxt = wd_cnt + 1'b1;
  assign wd_hit = (state == ST_RUN) && (int'(wd_nxt) == MAX_CYCLES);

  // Count RUN cycles since the accepted start
  always_ff @(posedge clk) begin
    if (!rst_n)                             wd_cnt <= '0;
    else if (state == ST_IDLE && sif.start) wd_cnt <= '0;
    else if (state == ST_RUN)               wd_cnt <= wd_nxt;
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Run FSM with fetch pointer, squash tracking, loop counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      dvld     <= 1'b0;
      opcode_q <= '0;
      exec_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      loop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          exec_q <= 1'b0;
          done_q <= 1'b0;
          if (sif.start) begin
            state  <= ST_RUN;
            pc     <= '0;
            busy_q <= 1'b1;
            dvld   <= 1'b0;
            ovr_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt || wd_hit) begin
            // HALT takes priority over a coincident watchdog expiry
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            exec_q <= 1'b0;
            dvld   <= 1'b0;
            ovr_q  <= !halt;
          end else begin
            pc     <= redirect ? tgt : pc + 1'b1;
            dvld   <= !redirect;            // word already in flight is squashed
            exec_q <= v && !dec.is_ctrl;
            if (v && !dec.is_ctrl) opcode_q <= sif.prog_data;
            if (v && dec.is_setloop)         loop_cnt <= dec.target;
            else if (redirect && dec.is_loop) loop_cnt <= loop_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sif.prog_addr = pc;
  assign sif.opcode    = opcode_q;
  assign sif.execute   = exec_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.overrun   = ovr_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed programs plus random loop/jump programs
// checked against an instruction-level model of the sequencer.
module tb_core_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if #(.ADDR_W(8)) sif ();
  core_sequencer_if #(.ADDR_W(4)) sif4 ();
  core_sequencer #(.ADDR_W(8), .MAX_CYCLES(255)) dut  (.clk(clk), .rst_n(rst_n), .sif(sif));
  core_sequencer #(.ADDR_W(4), .MAX_CYCLES(20))  dut4 (.clk(clk), .rst_n(rst_n), .sif(sif4));

  logic [15:0] mem  [256];
  logic [15:0] mem4 [16];
  // Program memories: data valid one cycle after the address
  always @(posedge clk) sif.prog_data  <= mem[sif.prog_addr];
  always @(posedge clk) sif4.prog_data <= mem4[sif4.prog_addr];

  int n_pass = 0, n_chk = 0;
  logic [15:0] expq[$], gotq[$];
  int mdl_lc = 0;
  int exp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rnd_core();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:14] == 2'b11) w[8] = 1'b1;
    return w;
  endfunction

  // Instruction-level interpretation: executed core ops, and done latency of
  // 2 fetch cycles + 1 cycle per instruction + 1 bubble per taken branch.
  task automatic model();
    int pc, n, taken;
    logic [15:0] w;
    pc = 0; n = 0; taken = 0;
    expq.delete();
    for (int s = 0; s < 2000; s++) begin
      w = mem[pc];
      n++;
      if (w[15:14] != 2'b11 || w[8]) begin expq.push_back(w); pc = (pc + 1) % 256; end
      else if (w[13:12] == 2'b01) break;
      else if (w[13:12] == 2'b10) begin pc = int'(w[7:0]); taken++; end
      else if (w[13:11] == 3'b110) begin mdl_lc = int'(w[7:0]); pc = (pc + 1) % 256; end
      else if (w[13:11] == 3'b111 && mdl_lc != 0) begin mdl_lc--; pc = int'(w[7:0]); taken++; end
      else pc = (pc + 1) % 256;
    end
    exp_done = 2 + n + taken;
  endtask

  task automatic run(input string tag);
    int cyc, done_at;
    model();
    gotq.delete();
    done_at = -1;
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    cyc = 1;
    check({tag, ".busy1"}, 32'(sif.busy), 32'd1);
    check({tag, ".addr0"}, 32'(sif.prog_addr), 32'd0);
    while (cyc < 400 && done_at < 0) begin
      tick(); cyc++;
      if (sif.execute) gotq.push_back(sif.opcode);
      if (sif.done) done_at = cyc;
    end
    check({tag, ".done_at"}, 32'(done_at), 32'(exp_done));
    check({tag, ".busy_at_done"}, 32'(sif.busy), 32'd0);
    check({tag, ".nexec"}, 32'(gotq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < gotq.size()) check({tag, ".op"}, 32'(gotq[i]), 32'(expq[i]));
    tick();
    check({tag, ".done_pulse"}, 32'(sif.done), 32'd0);
  endtask

  task automatic load(input logic [15:0] p0, input logic [15:0] p1,
                      input logic [15:0] p2, input logic [15:0] p3);
    for (int i = 0; i < 256; i++) mem[i] = rnd_core();
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
  endtask

  initial begin
    int cyc, done_at, cnt, k, m, p;
    sif.start = 1'b0; sif4.start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0;

    // Reset state
    rst_n = 1'b0; tick(); tick();
    check("rst.addr", 32'(sif.prog_addr), 32'd0);
    check("rst.opcode", 32'(sif.opcode), 32'd0);
    check("rst.outs", {28'd0, sif.execute, sif.busy, sif.done, sif.overrun}, 32'd0);
    check("rst.lc", 32'(dut.loop_cnt), 32'd0);
    rst_n = 1'b1; tick();

    // Straight line with HALT
    load(16'h0005, 16'h1A03, 16'h5000, 16'hD000);
    run("t1");
    check("t1.opcode_hold", 32'(sif.opcode), 32'h5000);

    // JUMP over a word that must be squashed
    load(16'h1111, 16'hE010, 16'h4242, 16'h2222);
    mem[16] = 16'hD000;
    run("t2");

    // SETLOOP 2 -> three body iterations
    load(16'hF002, 16'h6000, 16'hF801, 16'hD000);
    run("t3");
    check("t3.lc_end", 32'(dut.loop_cnt), 32'd0);

    // Class-MISC word with bit 8 set goes to the cores
    load(16'hC100, 16'hD000, 16'h0, 16'h0);
    run("t6");

    // Random loop/jump programs
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = rnd_core();
      k = $urandom_range(0, 3); m = $urandom_range(1, 4); p = $urandom_range(0, 3);
      mem[0] = 16'hF000 | 16'(k);
      for (int i = 1; i <= m; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? (16'hC000 | (16'($urandom) & 16'h08FF)) : rnd_core();
      mem[m+1] = 16'hF801;
      mem[m+2] = 16'hE000 | 16'(m + 4);
      mem[m+3] = 16'hD000;
      for (int i = 0; i < p; i++) mem[m+4+i] = rnd_core();
      mem[m+4+p] = 16'hD000;
      run("rnd");
    end

    // start held high: back-to-back runs, one per IDLE entry
    load(16'h0005, 16'h1A03, 16'h5000, 16'hD000);
    sif.start = 1'b1; tick();
    cyc = 1; done_at = -1;
    while (cyc < 30 && done_at < 0) begin tick(); cyc++; if (sif.done) done_at = cyc; end
    check("t4.done_at", 32'(done_at), 32'd6);
    check("t4.busy_at_done", 32'(sif.busy), 32'd0);
    tick();
    check("t4.rerun_busy", 32'(sif.busy), 32'd1);
    check("t4.rerun_addr", 32'(sif.prog_addr), 32'd0);
    sif.start = 1'b0;
    cyc = 0; done_at = -1;
    while (cyc < 30 && done_at < 0) begin tick(); cyc++; if (sif.done) done_at = cyc; end
    check("t4.second_done", 32'(done_at), 32'd5);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (sif.busy) cnt++; end
    check("t4.no_third_run", 32'(cnt), 32'd0);

    // Reset mid-run
    sif.start = 1'b1; tick(); sif.start = 1'b0; tick(); tick();
    rst_n = 1'b0; tick();
    check("t4.rst_outs", {sif.prog_addr, sif.opcode, sif.execute, sif.busy, sif.done, sif.overrun}, 32'd0);
    rst_n = 1'b1; mdl_lc = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (sif.done || sif.busy) cnt++; end
    check("t4.no_done_after_rst", 32'(cnt), 32'd0);

    // start already high when reset releases
    rst_n = 1'b0; sif.start = 1'b1; tick();
    rst_n = 1'b1; tick(); sif.start = 1'b0;
    check("t4.start_at_rst_rel", 32'(sif.busy), 32'd1);
    cyc = 1; done_at = -1;
    while (cyc < 30 && done_at < 0) begin tick(); cyc++; if (sif.done) done_at = cyc; end
    check("t4.rst_rel_done", 32'(done_at), 32'd6);

    // ADDR_W=4: no HALT, address wraps 15 -> 0
    for (int i = 0; i < 16; i++) mem4[i] = rnd_core();
    sif4.start = 1'b1; tick(); sif4.start = 1'b0;
    check("t5.addr_first", 32'(sif4.prog_addr), 32'd0);
    for (cyc = 2; cyc <= 17; cyc++) begin
      tick();
      if (cyc == 16) check("t5.addr15", 32'(sif4.prog_addr), 32'd15);
      if (cyc == 17) check("t5.addr_wrap", 32'(sif4.prog_addr), 32'd0);
    end
`ifdef SEQ_WATCHDOG_EN
    done_at = -1;
    while (cyc < 60 && done_at < 0) begin tick(); cyc++; if (sif4.done) done_at = cyc - 1; end
    check("t5.wd_done_at", 32'(done_at), 32'd21);
    check("t5.wd_overrun", 32'(sif4.overrun), 32'd1);
    tick();
    check("t5.overrun_sticky", {30'd0, sif4.overrun, sif4.done}, 32'd2);
`else
    while (cyc < 40) begin tick(); cyc++; end
    check("t5.runs_forever", {30'd0, sif4.busy, sif4.overrun}, 32'd2);
    rst_n = 1'b0; tick(); rst_n = 1'b1; mdl_lc = 0; tick();
`endif

    // HALT decoded in the 20th RUN cycle: with the watchdog it coincides and HALT wins
    mem4[0] = 16'hE001; mem4[1] = 16'hE002; mem4[2] = 16'hE003;
    for (int i = 3; i < 15; i++) mem4[i] = rnd_core();
    mem4[15] = 16'hD000;
    sif4.start = 1'b1; tick(); sif4.start = 1'b0;
    check("t5.overrun_cleared", 32'(sif4.overrun), 32'd0);
    cyc = 1; done_at = -1; cnt = 0;
    while (cyc < 60 && done_at < 0) begin
      tick(); cyc++;
      if (sif4.execute) cnt++;
      if (sif4.done) done_at = cyc;
    end
    check("t5.halt_done_at", 32'(done_at), 32'd21);
    check("t5.halt_no_overrun", 32'(sif4.overrun), 32'd0);
    check("t5.halt_nexec", 32'(cnt), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
